// File: rtl/wavelet_pkg.sv
// Shared wavelet definitions: default sample width, saturation limits,
// synthesis FSM states and a default-width saturating add/subtract helper.
package wavelet_pkg;

  localparam int ADC_WIDTH_DEF = 14;

  localparam logic signed [ADC_WIDTH_DEF-1:0] SMAX = {1'b0, {(ADC_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [ADC_WIDTH_DEF-1:0] SMIN = {1'b1, {(ADC_WIDTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } idwt_state_t;

  // Returns {clipped, result}; one guard bit is enough for a single add/sub.
  function automatic logic [ADC_WIDTH_DEF:0] sat_add(
    input logic signed [ADC_WIDTH_DEF-1:0] a,
    input logic signed [ADC_WIDTH_DEF-1:0] b,
    input logic                            sub
  );
    logic signed [ADC_WIDTH_DEF:0] s;
    s = sub ? ({a[ADC_WIDTH_DEF-1], a} - {b[ADC_WIDTH_DEF-1], b})
            : ({a[ADC_WIDTH_DEF-1], a} + {b[ADC_WIDTH_DEF-1], b});
    if (s[ADC_WIDTH_DEF] != s[ADC_WIDTH_DEF-1])
      sat_add = {1'b1, (s[ADC_WIDTH_DEF] ? SMIN : SMAX)};
    else
      sat_add = {1'b0, s[ADC_WIDTH_DEF-1:0]};
  endfunction

endpackage

// File: rtl/wav_sat_addsub.sv
// Combinational saturating adder/subtractor (y = a +/- b clipped to W bits).
// With HAAR_IDWT_SAT_CNT_EN the clip indication is exported on 'clipped'.
module wav_sat_addsub #(
  parameter int W = 14
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
`ifdef HAAR_IDWT_SAT_CNT_EN
  output logic                clipped,
`endif
  output logic signed [W-1:0] y
);

  function automatic logic [W:0] sat(input logic signed [W:0] s);
    if (s[W] != s[W-1])
      sat = s[W] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
    else
      sat = {1'b0, s[W-1:0]};
  endfunction

  logic signed [W:0] a_x;
  logic signed [W:0] b_x;
  logic signed [W:0] s;
  logic        [W:0] r;

  assign a_x = {a[W-1], a};
  assign b_x = {b[W-1], b};
  assign s   = sub ? (a_x - b_x) : (a_x + b_x);
  assign r   = sat(s);
  assign y   = r[W-1:0];
`ifdef HAAR_IDWT_SAT_CNT_EN
  assign clipped = r[W];
`endif

endmodule

// File: rtl/haar_idwt_synth.sv
// Single-level Haar inverse DWT: each (a,d) pair yields sat(a+d) then sat(a-d).
// HAAR_IDWT_SAT_CNT_EN adds sat_cnt/sat_flag clip monitoring outputs.
module haar_idwt_synth
  import wavelet_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [ADC_WIDTH-1:0] approx_level,
  input  logic signed [ADC_WIDTH-1:0] detail_level,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [ADC_WIDTH-1:0] recon_out,
  output logic                        out_valid,
`ifdef HAAR_IDWT_SAT_CNT_EN
  output logic [15:0]                 sat_cnt,
  output logic [0:0]                  sat_flag,
`endif
  input  logic                        out_ready
);

  idwt_state_t state;
  logic signed [ADC_WIDTH-1:0] a_q;
  logic signed [ADC_WIDTH-1:0] d_q;
  logic signed [ADC_WIDTH-1:0] op_a;
  logic signed [ADC_WIDTH-1:0] op_b;
  logic signed [ADC_WIDTH-1:0] res;
  logic accept;
  logic load;
  logic op_sub;

  assign in_ready = (state == IDLE) || ((state == ODD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept || ((state == EVEN) && out_ready);

  // One shared adder: fresh pair gives the even sample, held pair the odd one.
  assign op_sub = !accept;
  assign op_a   = accept ? approx_level : a_q;
  assign op_b   = accept ? detail_level : d_q;

`ifdef HAAR_IDWT_SAT_CNT_EN
  logic clip;

  wav_sat_addsub #(.W(ADC_WIDTH)) u_addsub (
    .a       (op_a),
    .b       (op_b),
    .sub     (op_sub),
    .clipped (clip),
    .y       (res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_cnt  <= 16'd0;
      sat_flag <= 1'b0;
    end else if (load) begin
      sat_flag <= clip;
      if (clip && (sat_cnt != 16'hFFFF))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  wav_sat_addsub #(.W(ADC_WIDTH)) u_addsub (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .y   (res)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      a_q       <= '0;
      d_q       <= '0;
      recon_out <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= approx_level;
        d_q <= detail_level;
      end
      if (load)
        recon_out <= res;
      case (state)
        IDLE: if (in_valid) begin
          out_valid <= 1'b1;
          state     <= EVEN;
        end
        EVEN: if (out_ready) state <= ODD;
        ODD: if (out_ready) begin
          if (in_valid) begin
            state <= EVEN;
          end else begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_haar_idwt_synth.sv
// Directed and randomized checks of haar_idwt_synth handshakes, ordering and saturation.
module tb_haar_idwt_synth;

  localparam int W = 14;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic signed [W-1:0] approx_level = '0;
  logic signed [W-1:0] detail_level = '0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] recon_out;
  logic                out_valid;
`ifdef HAAR_IDWT_SAT_CNT_EN
  logic [15:0]         sat_cnt;
  logic [0:0]          sat_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  haar_idwt_synth dut (
    .clk          (clk),
    .rstn         (rstn),
    .approx_level (approx_level),
    .detail_level (detail_level),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .recon_out    (recon_out),
    .out_valid    (out_valid),
`ifdef HAAR_IDWT_SAT_CNT_EN
    .sat_cnt      (sat_cnt),
    .sat_flag     (sat_flag),
`endif
    .out_ready    (out_ready)
  );

  function automatic int ref_sat(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (recon_out !== 0) begin n_err++; $display("FAIL rst_recon: got %0d want 0", recon_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
`ifdef HAAR_IDWT_SAT_CNT_EN
    n_cmp++; if (sat_cnt !== 16'd0) begin n_err++; $display("FAIL rst_sat_cnt: got %0d want 0", sat_cnt); end
`endif
    rstn = 1'b1;
    tick();
    approx_level = 50; detail_level = 5; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || recon_out !== 55) begin n_err++; $display("FAIL rst_pre_even: got v=%0b %0d want v=1 55", out_valid, recon_out); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %0b want 0", out_valid); end
    n_cmp++; if (recon_out !== 0) begin n_err++; $display("FAIL rst_async_recon: got %0d want 0", recon_out); end
    tick();
    rstn = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release: got rdy=%0b v=%0b want rdy=1 v=0", in_ready, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_hold: got %0b want 0", out_valid); end
  endtask

  task automatic test_nominal;
    out_ready = 1'b1;
    approx_level = 100; detail_level = -30; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL nom_in_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || recon_out !== 70) begin n_err++; $display("FAIL nom_even: got v=%0b %0d want v=1 70", out_valid, recon_out); end
    tick(); #1;
    n_cmp++; if (out_valid !== 1'b1 || recon_out !== 130) begin n_err++; $display("FAIL nom_odd: got v=%0b %0d want v=1 130", out_valid, recon_out); end
    tick(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nom_done: got v=%0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int av[3] = '{10, 20, 0};
    int dv[3] = '{2, -5, 0};
    int ev[3] = '{12, 15, 0};
    int ov[3] = '{8, 25, 0};
    out_ready = 1'b1;
    approx_level = av[0]; detail_level = dv[0]; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, in_ready); end
      tick();
      if (i < 2) begin approx_level = av[i+1]; detail_level = dv[i+1]; end
      else in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b1 || recon_out !== ev[i]) begin n_err++; $display("FAIL b2b_even_%0d: got v=%0b %0d want v=1 %0d", i, out_valid, recon_out, ev[i]); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy_%0d: got %0b want 0", i, in_ready); end
      tick(); #1;
      n_cmp++; if (out_valid !== 1'b1 || recon_out !== ov[i]) begin n_err++; $display("FAIL b2b_odd_%0d: got v=%0b %0d want v=1 %0d", i, out_valid, recon_out, ov[i]); end
    end
    tick(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_done: got v=%0b want 0", out_valid); end
  endtask

  task automatic test_saturation;
    int av[2] = '{5000, -5000};
    int dv[2] = '{4000, 4000};
    int ev[2] = '{8191, -1000};
    int ov[2] = '{1000, -8192};
    out_ready = 1'b1;
    approx_level = av[0]; detail_level = dv[0]; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i < 1) begin approx_level = av[i+1]; detail_level = dv[i+1]; end
      else in_valid = 1'b0;
      #1;
      n_cmp++; if (recon_out !== ev[i]) begin n_err++; $display("FAIL sat_even_%0d: got %0d want %0d", i, recon_out, ev[i]); end
`ifdef HAAR_IDWT_SAT_CNT_EN
      n_cmp++; if (sat_flag !== (i == 0)) begin n_err++; $display("FAIL sat_flag_even_%0d: got %0b want %0b", i, sat_flag, (i == 0)); end
`endif
      tick(); #1;
      n_cmp++; if (recon_out !== ov[i]) begin n_err++; $display("FAIL sat_odd_%0d: got %0d want %0d", i, recon_out, ov[i]); end
`ifdef HAAR_IDWT_SAT_CNT_EN
      n_cmp++; if (sat_flag !== (i == 1)) begin n_err++; $display("FAIL sat_flag_odd_%0d: got %0b want %0b", i, sat_flag, (i == 1)); end
`endif
    end
    tick(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sat_done: got v=%0b want 0", out_valid); end
`ifdef HAAR_IDWT_SAT_CNT_EN
    n_cmp++; if (sat_cnt !== 16'd2) begin n_err++; $display("FAIL sat_cnt: got %0d want 2", sat_cnt); end
`endif
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    approx_level = 7; detail_level = 3; in_valid = 1'b1;
    tick();
    approx_level = 1000; detail_level = 1000;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || recon_out !== 10) begin n_err++; $display("FAIL bp_hold_%0d: got v=%0b %0d want v=1 10", i, out_valid, recon_out); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_%0d: got %0b want 0", i, in_ready); end
      tick(); #1;
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || recon_out !== 4) begin n_err++; $display("FAIL bp_odd: got v=%0b %0d want v=1 4", out_valid, recon_out); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_odd_ready: got %0b want 0", in_ready); end
    tick(); #1;
    n_cmp++; if (out_valid !== 1'b1 || recon_out !== 4) begin n_err++; $display("FAIL bp_odd_hold: got v=%0b %0d want v=1 4", out_valid, recon_out); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_odd_release: got %0b want 1", in_ready); end
    tick(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_done: got v=%0b want 0", out_valid); end
  endtask

  task automatic test_random;
    localparam int N = 2000;
    int q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int pa = 0;
    int pd = 0;
    int exp_v;
    bit have = 1'b0;
    while (got < 2 * N && cyc < 20000) begin
      if (!have && sent < N && $urandom_range(0, 3) != 0) begin
        pa = int'($urandom_range(0, 16383)) - 8192;
        pd = int'($urandom_range(0, 16383)) - 8192;
        have = 1'b1;
      end
      in_valid = have;
      approx_level = have ? pa : int'($urandom_range(0, 16383)) - 8192;
      detail_level = have ? pd : int'($urandom_range(0, 16383)) - 8192;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_extra: got sample %0d want none", recon_out);
        end else begin
          exp_v = q.pop_front();
          if (recon_out !== exp_v) begin n_err++; $display("FAIL rand_sample_%0d: got %0d want %0d", got, recon_out, exp_v); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sat(pa + pd));
        q.push_back(ref_sat(pa - pd));
        have = 1'b0;
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (got !== 2 * N) begin n_err++; $display("FAIL rand_count: got %0d samples want %0d", got, 2 * N); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
